time_param_timer: RTL

- Parametrised successor to the 4-entry time-parameter register bank in the automotive anti-theft system.
- Holds NUM_PARAMS reprogrammable time parameters of WIDTH bits each, with per-entry reset defaults.
- Adds an integrated countdown engine that loads a selected parameter, optionally doubled, and counts down on an external 1 Hz enable.
- Signals expiry with a one-cycle pulse. The alarm FSM no longer needs its own timer.

---
 rtl/time_param_timer.sv | 119 +++++++++++
 1 files changed

// File: rtl/time_param_timer.sv
// Reprogrammable bank of time parameters with an integrated countdown engine.
// Expiry is reported as a registered one-cycle pulse; busy follows the RUN state.
module time_param_timer #(
  parameter int NUM_PARAMS = 4,
  parameter int WIDTH      = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = {4'd10, 4'd15, 4'd8, 4'd6}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reprogram,
  input  logic [SEL_W-1:0] time_param_sel,
  input  logic [WIDTH-1:0] time_value,
  input  logic [SEL_W-1:0] interval,
  input  logic             double_time,
  input  logic             start_timer,
  input  logic             abort,
  input  logic             one_hz_enable,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH:0]   count,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [SEL_W:0] NUM_P_C = (SEL_W+1)'(NUM_PARAMS);

  logic [WIDTH-1:0] params_r [NUM_PARAMS];
  state_t           state_r, state_n_s;
  logic [WIDTH:0]   count_r, count_n_s;
  logic             expired_r, expired_n_s;
  logic [WIDTH-1:0] value_s;
  logic [WIDTH:0]   load_s;

  // Parameter bank: per-entry defaults on reset, out-of-range selects never match
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params_r[i] <= DEFAULTS[i*WIDTH +: WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (reprogram && (time_param_sel == SEL_W'(i))) begin
          params_r[i] <= time_value;
        end else begin
          params_r[i] <= params_r[i];
        end
      end
    end
  end

  // Read port and load value; the load uses the stored (pre-write) entry
  always_comb begin
    value_s = {WIDTH{1'b0}};
    load_s  = {(WIDTH+1){1'b0}};
    if ({1'b0, interval} < NUM_P_C) begin
      value_s = params_r[interval];
    end else begin
      value_s = {WIDTH{1'b0}};
    end
    if (double_time) begin
      load_s = {value_s, 1'b0};
    end else begin
      load_s = {1'b0, value_s};
    end
  end

  // Countdown FSM next-state logic; abort has priority over start
  always_comb begin
    state_n_s   = state_r;
    count_n_s   = count_r;
    expired_n_s = 1'b0;
    if (abort) begin
      state_n_s = ST_IDLE;
    end else if (start_timer) begin
      state_n_s = ST_RUN;
      count_n_s = load_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n_s = ST_IDLE;
        end
        ST_RUN: begin
          if (count_r == {(WIDTH+1){1'b0}}) begin
            state_n_s   = ST_IDLE;
            expired_n_s = 1'b1;
          end else if (one_hz_enable) begin
            count_n_s = count_r - (WIDTH+1)'(1);
          end else begin
            count_n_s = count_r;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, count and expiry pulse registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      count_r   <= {(WIDTH+1){1'b0}};
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      count_r   <= count_n_s;
      expired_r <= expired_n_s;
    end
  end

  assign value   = value_s;
  assign count   = count_r;
  assign busy    = (state_r == ST_RUN);
  assign expired = expired_r;

endmodule
